wb_rstctl: RTL and testbench



---
 rtl/wb_rstctl_pkg.sv | 24 ++
 rtl/wb_rst_sync.sv | 23 ++
 rtl/wb_rstctl.sv | 106 ++++++++++
 tb/tb_wb_rstctl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/wb_rstctl_pkg.sv
// wb_rstctl_pkg: shared state encoding, reset-cause codes and counter sizing for the reset controller
package wb_rstctl_pkg;

    typedef enum logic [2:0] {
        ST_ASYNC,
        ST_STRETCH,
        ST_HOLD,
        ST_SWRST,
        ST_RUN
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_POR  = 2'b01;
    localparam logic [1:0] CAUSE_SYNC = 2'b10;
    localparam logic [1:0] CAUSE_SW   = 2'b11;

    // Width of a down-counter whose largest load value is max(a,b)-1, never below 1 bit
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/wb_rst_sync.sv
// wb_rst_sync: async-set / sync-clear reset synchronizer chain
module wb_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic rst_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q;

    // Set every stage at once on reset; shift zeros toward the output stage afterwards
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) chain_q <= '1;
        else       chain_q <= {chain_q[STAGES-2:0], 1'b0};
    end

    assign rst_o  = chain_q[STAGES-1];
    // High during the cycle whose closing edge drops rst_o
    assign fall_o = chain_q[STAGES-1] & ~chain_q[STAGES-2];

endmodule

// File: rtl/wb_rstctl.sv
// wb_rstctl: Wishbone SYSCON reset controller producing synchronized, stretched and software resets
module wb_rstctl
    import wb_rstctl_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int POR_CYCLES   = 4,
    parameter int SWRST_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       async_rst_i,
    input  logic       sync_rst_i,
    input  logic       swrst_req_i,
    output logic       swrst_ack_o,
    output logic       async_rst_o,
    output logic       sync_rst_o,
    output logic       rst_done_o,
    output logic [1:0] rst_cause_o
);

    localparam int CW = cnt_width(POR_CYCLES, SWRST_CYCLES);
    localparam logic [CW-1:0] POR_LOAD = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] SW_LOAD  = CW'(SWRST_CYCLES - 1);

    logic          sync_fall;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    cause_q, cause_d;
    logic          ack_q, ack_d;
    logic          sync_rst_q, done_q;

    wb_rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i  (clk_i),
        .rst_i  (async_rst_i),
        .rst_o  (async_rst_o),
        .fall_o (sync_fall)
    );

    // Next-state logic; sync_rst_i outranks swrst_req_i, and requests outside RUN are dropped
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        ack_d   = 1'b0;
        case (state_q)
            ST_ASYNC: begin
                if (sync_fall) begin
                    state_d = ST_STRETCH;
                    cnt_d   = POR_LOAD;
                end
            end
            ST_STRETCH, ST_SWRST: begin
                if (sync_rst_i) begin
                    state_d = ST_HOLD;
                    cause_d = CAUSE_SYNC;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HOLD: begin
                if (!sync_rst_i) begin
                    state_d = ST_STRETCH;
                    cnt_d   = POR_LOAD;
                end
            end
            ST_RUN: begin
                if (sync_rst_i) begin
                    state_d = ST_HOLD;
                    cause_d = CAUSE_SYNC;
                end else if (swrst_req_i) begin
                    state_d = ST_SWRST;
                    cnt_d   = SW_LOAD;
                    cause_d = CAUSE_SW;
                    ack_d   = 1'b1;
                end
            end
            default: state_d = ST_ASYNC;
        endcase
    end

    // State and registered outputs; raw async reset forces the power-on state immediately
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_q    <= ST_ASYNC;
            cnt_q      <= '0;
            cause_q    <= CAUSE_POR;
            ack_q      <= 1'b0;
            sync_rst_q <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cause_q    <= cause_d;
            ack_q      <= ack_d;
            sync_rst_q <= (state_d != ST_RUN);
            done_q     <= (state_d == ST_RUN);
        end
    end

    assign swrst_ack_o = ack_q;
    assign sync_rst_o  = sync_rst_q;
    assign rst_done_o  = done_q;
    assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_wb_rstctl.sv
// tb_wb_rstctl: directed checks of the reset controller at default and swept parameters
module tb_wb_rstctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_arst = 1'b0, a_srst = 1'b0, a_sw = 1'b0;
    logic       a_ack, a_async, a_sync, a_done;
    logic [1:0] a_cause;

    logic       b_arst = 1'b0, b_srst = 1'b0, b_sw = 1'b0;
    logic       b_ack, b_async, b_sync, b_done;
    logic [1:0] b_cause;

    int total = 0;
    int bad = 0;

    wb_rstctl u_a (
        .clk_i       (clk),
        .async_rst_i (a_arst),
        .sync_rst_i  (a_srst),
        .swrst_req_i (a_sw),
        .swrst_ack_o (a_ack),
        .async_rst_o (a_async),
        .sync_rst_o  (a_sync),
        .rst_done_o  (a_done),
        .rst_cause_o (a_cause)
    );

    wb_rstctl #(.SYNC_STAGES(3), .POR_CYCLES(1), .SWRST_CYCLES(7)) u_b (
        .clk_i       (clk),
        .async_rst_i (b_arst),
        .sync_rst_i  (b_srst),
        .swrst_req_i (b_sw),
        .swrst_ack_o (b_ack),
        .async_rst_o (b_async),
        .sync_rst_o  (b_sync),
        .rst_done_o  (b_done),
        .rst_cause_o (b_cause)
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic nedge(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // power-on: raw reset held ~3 cycles, released mid-period at t=30
        #1 a_arst = 1'b1;
        #1;
        chk("por_async_o", {1'b0, a_async}, 2'b01);
        chk("por_sync_o",  {1'b0, a_sync},  2'b01);
        chk("por_done",    {1'b0, a_done},  2'b00);
        chk("por_ack",     {1'b0, a_ack},   2'b00);
        chk("por_cause",   a_cause,         2'b01);
        nedge(3);
        a_arst = 1'b0;
        nedge(1);
        chk("por_edge1_async", {1'b0, a_async}, 2'b01);
        nedge(1);
        chk("por_edge2_async", {1'b0, a_async}, 2'b00);
        chk("por_edge2_sync",  {1'b0, a_sync},  2'b01);
        nedge(3);
        chk("por_stretch_sync", {1'b0, a_sync}, 2'b01);
        chk("por_stretch_done", {1'b0, a_done}, 2'b00);
        nedge(1);
        chk("por_run_sync",  {1'b0, a_sync}, 2'b00);
        chk("por_run_done",  {1'b0, a_done}, 2'b01);
        chk("por_run_cause", a_cause,        2'b01);

        // sync reset held for 5 edges
        a_srst = 1'b1;
        nedge(1);
        chk("srst_sync",  {1'b0, a_sync},  2'b01);
        chk("srst_done",  {1'b0, a_done},  2'b00);
        chk("srst_cause", a_cause,         2'b10);
        chk("srst_async", {1'b0, a_async}, 2'b00);
        nedge(4);
        chk("srst_hold_sync", {1'b0, a_sync}, 2'b01);
        a_srst = 1'b0;
        nedge(4);
        chk("srst_stretch_sync", {1'b0, a_sync}, 2'b01);
        nedge(1);
        chk("srst_run_sync",  {1'b0, a_sync}, 2'b00);
        chk("srst_run_done",  {1'b0, a_done}, 2'b01);
        chk("srst_run_cause", a_cause,        2'b10);

        // software reset: one-cycle request in RUN
        a_sw = 1'b1;
        nedge(1);
        a_sw = 1'b0;
        chk("sw_ack",   {1'b0, a_ack},  2'b01);
        chk("sw_sync",  {1'b0, a_sync}, 2'b01);
        chk("sw_cause", a_cause,        2'b11);
        chk("sw_done",  {1'b0, a_done}, 2'b00);
        nedge(1);
        chk("sw_ack_drop", {1'b0, a_ack},  2'b00);
        chk("sw_sync2",    {1'b0, a_sync}, 2'b01);
        nedge(2);
        chk("sw_sync4", {1'b0, a_sync}, 2'b01);
        nedge(1);
        chk("sw_end_sync", {1'b0, a_sync}, 2'b00);
        chk("sw_end_done", {1'b0, a_done}, 2'b01);

        // conflict 1: software request while stretching is dropped
        a_srst = 1'b1;
        nedge(1);
        a_srst = 1'b0;
        nedge(1);
        a_sw = 1'b1;
        nedge(1);
        a_sw = 1'b0;
        chk("cf1_ack",  {1'b0, a_ack},  2'b00);
        chk("cf1_sync", {1'b0, a_sync}, 2'b01);
        nedge(2);
        chk("cf1_last_sync", {1'b0, a_sync}, 2'b01);
        nedge(1);
        chk("cf1_run_done", {1'b0, a_done}, 2'b01);
        chk("cf1_cause",    a_cause,        2'b10);

        // conflict 2: sync and software request together in RUN
        a_srst = 1'b1;
        a_sw   = 1'b1;
        nedge(1);
        a_srst = 1'b0;
        a_sw   = 1'b0;
        chk("cf2_ack",   {1'b0, a_ack},  2'b00);
        chk("cf2_cause", a_cause,        2'b10);
        chk("cf2_sync",  {1'b0, a_sync}, 2'b01);
        nedge(5);
        chk("cf2_run_done", {1'b0, a_done}, 2'b01);

        // abort: short async pulse during cycle 2 of SWRST
        a_sw = 1'b1;
        nedge(1);
        a_sw = 1'b0;
        chk("ab_ack", {1'b0, a_ack}, 2'b01);
        nedge(1);
        chk("ab_in_sw", {1'b0, a_sync}, 2'b01);
        a_arst = 1'b1;
        #1;
        chk("ab_async_now", {1'b0, a_async}, 2'b01);
        chk("ab_cause",     a_cause,         2'b01);
        chk("ab_done",      {1'b0, a_done},  2'b00);
        #1 a_arst = 1'b0;
        nedge(1);
        chk("ab_edge1_async", {1'b0, a_async}, 2'b01);
        nedge(1);
        chk("ab_edge2_async", {1'b0, a_async}, 2'b00);
        nedge(3);
        chk("ab_stretch_sync", {1'b0, a_sync}, 2'b01);
        nedge(1);
        chk("ab_run_sync",  {1'b0, a_sync}, 2'b00);
        chk("ab_run_done",  {1'b0, a_done}, 2'b01);
        chk("ab_run_cause", a_cause,        2'b01);

        // parameter sweep: 3 sync stages, 1-cycle stretch, 7-cycle software reset
        b_arst = 1'b1;
        #1;
        chk("b_por_async", {1'b0, b_async}, 2'b01);
        chk("b_por_sync",  {1'b0, b_sync},  2'b01);
        nedge(1);
        b_arst = 1'b0;
        nedge(2);
        chk("b_edge2_async", {1'b0, b_async}, 2'b01);
        nedge(1);
        chk("b_edge3_async", {1'b0, b_async}, 2'b00);
        chk("b_stretch_sync", {1'b0, b_sync}, 2'b01);
        nedge(1);
        chk("b_run_sync", {1'b0, b_sync}, 2'b00);
        chk("b_run_done", {1'b0, b_done}, 2'b01);
        b_sw = 1'b1;
        nedge(1);
        b_sw = 1'b0;
        chk("b_sw_ack",   {1'b0, b_ack},  2'b01);
        chk("b_sw_cause", b_cause,        2'b11);
        nedge(1);
        chk("b_sw_ack_drop", {1'b0, b_ack}, 2'b00);
        nedge(5);
        chk("b_sw_sync7", {1'b0, b_sync}, 2'b01);
        nedge(1);
        chk("b_sw_end_sync", {1'b0, b_sync}, 2'b00);
        chk("b_sw_end_done", {1'b0, b_done}, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
